// File: rtl/p_mul_arb.sv
// Two-requester round-robin front end for a packed multiplier: grants one operation,
// drives it to the multiplier, and returns the result (or an error) to its owner.
module p_mul_arb #(
   parameter int unsigned TIMEOUT = 40
) (
   input  logic        clock,
   input  logic        resetn,

   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic        req0_mul_l,
   input  logic        req0_mul_h,
   input  logic        req0_clmul,
   input  logic [4:0]  req0_pw,
   input  logic [31:0] req0_crs1,
   input  logic [31:0] req0_crs2,

   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic        req1_mul_l,
   input  logic        req1_mul_h,
   input  logic        req1_clmul,
   input  logic [4:0]  req1_pw,
   input  logic [31:0] req1_crs1,
   input  logic [31:0] req1_crs2,

   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_result,
   output logic        rsp0_err,

   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_result,
   output logic        rsp1_err,

   output logic        mul_valid,
   input  logic        mul_ready,
   output logic        mul_mul_l,
   output logic        mul_mul_h,
   output logic        mul_clmul,
   output logic [4:0]  mul_pw,
   output logic [31:0] mul_crs1,
   output logic [31:0] mul_crs2,
   input  logic [31:0] mul_result
);

   localparam int unsigned CNT_W = 6;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              owner;
   logic              rr_ptr;
   logic              grant;
   logic              any_valid;
   logic              accept;
   logic [4:0]        grant_pw;
   logic              pw_legal;
   logic [CNT_W-1:0]  cnt;
   logic              timeout;
   logic              owner_rsp_ready;
   logic [31:0]       result_q;
   logic              err_q;

   // rr_ptr names the requester that wins when both are valid
   always_comb begin
      any_valid = req0_valid | req1_valid;
      if (req0_valid && req1_valid)
         grant = rr_ptr;
      else
         grant = req1_valid;
      accept   = (state == IDLE) && any_valid;
      grant_pw = grant ? req1_pw : req0_pw;
      pw_legal = (grant_pw != '0) && ((grant_pw & (grant_pw - 5'd1)) == '0);
      timeout  = (cnt == CNT_W'(TIMEOUT - 1));
      owner_rsp_ready = owner ? rsp1_ready : rsp0_ready;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept)
               state_nxt = pw_legal ? BUSY : DONE;
         end
         BUSY: begin
            if (mul_ready || timeout)
               state_nxt = DONE;
         end
         DONE: begin
            if (owner_rsp_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req0_ready  = (state == IDLE) && req0_valid && !grant;
      req1_ready  = (state == IDLE) && req1_valid && grant;
      mul_valid   = (state == BUSY);
      rsp0_valid  = (state == DONE) && !owner;
      rsp1_valid  = (state == DONE) && owner;
      rsp0_result = owner ? '0 : result_q;
      rsp1_result = owner ? result_q : '0;
      rsp0_err    = !owner && err_q;
      rsp1_err    = owner && err_q;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         owner     <= 1'b0;
         rr_ptr    <= 1'b0;
         cnt       <= '0;
         mul_mul_l <= 1'b0;
         mul_mul_h <= 1'b0;
         mul_clmul <= 1'b0;
         mul_pw    <= '0;
         mul_crs1  <= '0;
         mul_crs2  <= '0;
         result_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         if (accept) begin
            owner     <= grant;
            rr_ptr    <= ~grant;
            cnt       <= '0;
            mul_mul_l <= grant ? req1_mul_l : req0_mul_l;
            mul_mul_h <= grant ? req1_mul_h : req0_mul_h;
            mul_clmul <= grant ? req1_clmul : req0_clmul;
            mul_pw    <= grant_pw;
            mul_crs1  <= grant ? req1_crs1 : req0_crs1;
            mul_crs2  <= grant ? req1_crs2 : req0_crs2;
            // An illegal pack width goes straight to DONE carrying this error
            result_q  <= '0;
            err_q     <= !pw_legal;
         end else if (state == BUSY) begin
            cnt <= cnt + CNT_W'(1);
            if (mul_ready) begin
               result_q <= mul_result;
               err_q    <= 1'b0;
            end else if (timeout) begin
               result_q <= '0;
               err_q    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/p_mul_arb.md
P_MUL_ARB -- requirements
Module: p_mul_arb

Interface
REQ-001 Parameter TIMEOUT, default 40, meaning the maximum number of BUSY cycles to wait for mul_ready before aborting (legal range 34..63).
REQ-002 clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous and active-low.
REQ-004 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-005 reqN_ready  output  1  operation accepted this cycle when high together with reqN_valid.
REQ-006 reqN_mul_l, reqN_mul_h, reqN_clmul  input  1 each  operation select bits from requester N.
REQ-007 reqN_pw  input  5  one-hot pack width {2,4,8,16,32} as bits [4:0].
REQ-008 reqN_crs1, reqN_crs2  input  32 each  operands from requester N.
REQ-009 rspN_valid  output  1  response for requester N available.
REQ-010 rspN_ready  input  1  requester N consumes the response.
REQ-011 rspN_result  output  32  result word; rspN_err  output  1  high when the operation was rejected or timed out.
REQ-012 mul_valid  output  1  drives the packed multiplier valid.
REQ-013 mul_ready  input  1  packed multiplier finish strobe.
REQ-014 mul_mul_l, mul_mul_h, mul_clmul  output  1 each; mul_pw  output  5; mul_crs1, mul_crs2  output  32 each  registered operation to the multiplier.
REQ-015 mul_result  input  32  multiplier result, valid only in the mul_ready cycle.

Function
REQ-016 Three states: IDLE, BUSY, DONE; a 1-bit owner register records the granted requester.
REQ-017 In IDLE, reqN_ready is asserted combinationally for exactly the granted requester; in BUSY and DONE both reqN_ready are 0.
REQ-018 Grant: if only one reqN_valid is high, that requester wins; if both are high, the requester not served last wins (round-robin pointer).
REQ-019 The round-robin pointer updates only on an accepted handshake and resets to favour requester 0.
REQ-020 On acceptance, owner, all operation fields and operands are registered, and the TIMEOUT counter clears.
REQ-021 Accept with legal one-hot pw: the next state is BUSY.
REQ-022 Accept with pw not one-hot (zero or multi-hot): the next state is DONE with result 0 and err 1; mul_valid is never raised for that operation.
REQ-023 In BUSY, mul_valid is 1 and all mul_* operation outputs hold constant until the cycle in which mul_ready is high.
REQ-024 In the mul_ready cycle of BUSY, mul_result is captured, err is cleared, and the next state is DONE; mul_valid is 0 from the following cycle.
REQ-025 The counter increments each BUSY cycle; if it reaches TIMEOUT without mul_ready, mul_valid drops, the result is 0, err is 1, and the next state is DONE.
REQ-026 If mul_ready and the timeout occur in the same cycle, mul_ready wins.
REQ-027 In DONE, rsp[owner]_valid is 1 with the stable captured result and err, and the other rspN_valid is 0.
REQ-028 In DONE, rsp[owner]_ready high returns the state to IDLE in the next cycle; the earliest next acceptance is that IDLE cycle.
REQ-029 Latency: an accept in cycle T and mul_ready in cycle T+k give rsp_valid from cycle T+k+1.
REQ-030 mul_ready seen outside BUSY is ignored.
REQ-031 reqN_valid changes during BUSY or DONE have no effect.
REQ-032 rspN_ready for the non-owner, or outside DONE, is ignored.

Reset
REQ-033 resetn low asynchronously forces: state IDLE, owner 0, pointer favouring requester 0, counter 0, mul_valid 0, all mul_* operation outputs 0, rspN_valid 0, rspN_result 0, rspN_err 0.
REQ-034 Reset asserted mid-operation (BUSY or DONE) discards the operation with no response.
REQ-035 The first cycle after reset release is IDLE.

Verification
REQ-036 req0 only, pw=5'b00001, crs1=3, crs2=5, mul_l; model the multiplier finishing after 33 cycles with result 15 -> req0_ready in the accept cycle, mul_valid high for 33 cycles with stable operands, rsp0_valid next cycle with result 15 and err 0.
REQ-037 req0 and req1 both valid continuously from reset -> grants alternate 0,1,0,1; rsp1_valid never asserts while owner=0.
REQ-038 req1 with pw=5'b00011 -> mul_valid stays 0, rsp1_valid 1 cycle after accept with result 0 and err 1.
REQ-039 Legal operation with mul_ready held low -> mul_valid drops after TIMEOUT=40 BUSY cycles, rsp with result 0 and err 1.
REQ-040 rsp0_ready held low for 10 cycles in DONE -> rsp0_valid, result and err stable, req1_ready stays 0 throughout.
REQ-041 resetn pulsed low in BUSY -> mul_valid 0 immediately without waiting for a clock edge, no response issued, next accept behaves as from power-up.
